rtc_access_arbiter: RTL and testbench

Shares the single RTC bus-transaction engine between three requesters: the init/write sequencer, the configuration-write path and the periodic read scanner. It grants one requester at a time and supports multi-transaction bursts with ownership lock. It drives the engine's enable/address/data/direction controls, waits for the engine's done flag and returns read data and an acknowledge to the owner. A watchdog aborts any transaction whose done flag never arrives.

---
 rtl/rtc_pkg.sv | 87 ++++++++
 rtl/rtc_watchdog_counter.sv | 27 ++
 rtl/rtc_access_arbiter.sv | 155 +++++++++++++++
 tb/tb_rtc_access_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC access arbiter: FSM encoding, requester indices,
// RTC register map and per-slot field extraction helpers.
package rtc_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } rtc_state_e;

    localparam int unsigned NUM_REQ = 3;

    localparam logic [1:0] REQ_INIT   = 2'd0;
    localparam logic [1:0] REQ_CONF   = 2'd1;
    localparam logic [1:0] REQ_READ   = 2'd2;
    localparam logic [1:0] OWNER_NONE = 2'd3;

    // Time/date registers
    localparam logic [7:0] ADDR_SEG     = 8'h21;
    localparam logic [7:0] ADDR_MIN     = 8'h22;
    localparam logic [7:0] ADDR_HORA    = 8'h23;
    localparam logic [7:0] ADDR_DIA     = 8'h24;
    localparam logic [7:0] ADDR_MES     = 8'h25;
    localparam logic [7:0] ADDR_ANIO    = 8'h26;
    localparam logic [7:0] ADDR_DIA_SEM = 8'h27;

    // Timer registers
    localparam logic [7:0] ADDR_T_SEG  = 8'h41;
    localparam logic [7:0] ADDR_T_MIN  = 8'h42;
    localparam logic [7:0] ADDR_T_HORA = 8'h43;

    // Command and control registers
    localparam logic [7:0] CMD_XFER_TIME  = 8'hF0;
    localparam logic [7:0] CMD_XFER_TIMER = 8'hF1;
    localparam logic [7:0] CMD_XFER_ALL   = 8'hF2;
    localparam logic [7:0] CTRL_STATUS    = 8'h02;
    localparam logic [7:0] CTRL_INIT      = 8'h10;

    typedef struct packed {
        logic       w_r;
        logic       last;
        logic [7:0] addr;
        logic [7:0] dato;
    } rtc_txn_t;

    function automatic rtc_txn_t slot_txn(
        input logic [1:0]           idx,
        input logic [NUM_REQ-1:0]   w_r,
        input logic [NUM_REQ-1:0]   last,
        input logic [8*NUM_REQ-1:0] addr,
        input logic [8*NUM_REQ-1:0] dato
    );
        rtc_txn_t t;
        t = '0;
        case (idx)
            REQ_INIT: t = '{w_r: w_r[0], last: last[0], addr: addr[7:0],   dato: dato[7:0]};
            REQ_CONF: t = '{w_r: w_r[1], last: last[1], addr: addr[15:8],  dato: dato[15:8]};
            REQ_READ: t = '{w_r: w_r[2], last: last[2], addr: addr[23:16], dato: dato[23:16]};
            default:  t = '0;
        endcase
        return t;
    endfunction

    function automatic logic req_of(input logic [1:0] idx, input logic [NUM_REQ-1:0] req);
        logic r;
        case (idx)
            REQ_INIT: r = req[0];
            REQ_CONF: r = req[1];
            REQ_READ: r = req[2];
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

    // OWNER_NONE maps to all-zero so a stray pulse can never reach a requester.
    function automatic logic [NUM_REQ-1:0] owner_onehot(input logic [1:0] idx);
        logic [NUM_REQ-1:0] oh;
        case (idx)
            REQ_INIT: oh = 3'b001;
            REQ_CONF: oh = 3'b010;
            REQ_READ: oh = 3'b100;
            default:  oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/rtc_watchdog_counter.sv
// Transaction watchdog: counts enabled cycles and flags when the limit is reached.
module rtc_watchdog_counter #(
    parameter int unsigned   TW    = 16,
    parameter logic [TW-1:0] LIMIT = '1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TW-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expire) begin
            count_q <= count_q + TW'(1);
        end
    end

    assign expire = enable && (count_q == LIMIT);

endmodule

// File: rtl/rtc_access_arbiter.sv
// Arbitrates the single RTC transaction engine between init, config-write and read-scan
// requesters, with burst ownership lock and a done-flag watchdog.
module rtc_access_arbiter
    import rtc_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
    parameter int unsigned TW             = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  in_req,
    input  logic [2:0]  in_w_r,
    input  logic [2:0]  in_last,
    input  logic [23:0] in_addr,
    input  logic [23:0] in_dato,
    input  logic        in_flag_done,
    input  logic [7:0]  in_dato_leido,
    output logic        out_en_funcion_rtc,
    output logic        out_funcion_w_r,
    output logic [7:0]  out_addr_ram_rtc,
    output logic [7:0]  out_dato_inicio,
    output logic [2:0]  out_ack,
    output logic [2:0]  out_err,
    output logic [7:0]  out_dato_rd,
    output logic [1:0]  out_owner
);

    // Expire on the last BUSY cycle so err lands TIMEOUT_CYCLES cycles after en rose.
    localparam logic [TW-1:0] WdLimit = TW'(TIMEOUT_CYCLES - 16'd1);

    rtc_state_e state_q;
    logic       lock_q;
    logic [1:0] owner_q;
    rtc_txn_t   txn_q;
    logic       en_q;
    logic [2:0] ack_q;
    logic [2:0] err_q;
    logic [7:0] dato_rd_q;

    logic       owner_req;
    logic       keep_lock;
    logic       grant_valid;
    logic [1:0] grant_idx;
    rtc_txn_t   grant_txn;
    logic       hold_lock;
    logic       wd_clear;
    logic       wd_enable;
    logic       wd_expire;

    always_comb begin
        owner_req   = req_of(owner_q, in_req);
        keep_lock   = lock_q && owner_req;
        grant_valid = 1'b1;
        grant_idx   = OWNER_NONE;
        if (keep_lock) begin
            grant_idx = owner_q;
        end else if (in_req[REQ_INIT]) begin
            grant_idx = REQ_INIT;
        end else if (in_req[REQ_CONF]) begin
            grant_idx = REQ_CONF;
        end else if (in_req[REQ_READ]) begin
            grant_idx = REQ_READ;
        end else begin
            grant_valid = 1'b0;
        end
        grant_txn = slot_txn(grant_idx, in_w_r, in_last, in_addr, in_dato);
        hold_lock = !txn_q.last && !(|err_q);
    end

    assign wd_enable = (state_q == StBusy);
    assign wd_clear  = (state_q != StBusy);

    rtc_watchdog_counter #(
        .TW    (TW),
        .LIMIT (WdLimit)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            lock_q    <= 1'b0;
            owner_q   <= OWNER_NONE;
            txn_q     <= '0;
            en_q      <= 1'b0;
            ack_q     <= '0;
            err_q     <= '0;
            dato_rd_q <= '0;
        end else begin
            ack_q <= '0;
            err_q <= '0;
            case (state_q)
                StIdle: begin
                    // Lock survives only while its owner keeps requesting.
                    lock_q <= keep_lock;
                    if (grant_valid) begin
                        txn_q   <= grant_txn;
                        owner_q <= grant_idx;
                        en_q    <= 1'b1;
                        state_q <= StBusy;
                    end else begin
                        owner_q <= OWNER_NONE;
                        en_q    <= 1'b0;
                    end
                end
                StBusy: begin
                    if (in_flag_done) begin
                        if (!txn_q.w_r) begin
                            dato_rd_q <= in_dato_leido;
                        end
                        ack_q   <= owner_onehot(owner_q);
                        en_q    <= 1'b0;
                        state_q <= StDone;
                    end else if (wd_expire) begin
                        err_q   <= owner_onehot(owner_q);
                        lock_q  <= 1'b0;
                        en_q    <= 1'b0;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    lock_q <= hold_lock;
                    if (!hold_lock) begin
                        owner_q <= OWNER_NONE;
                    end
                    en_q    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    en_q    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign out_en_funcion_rtc = en_q;
    assign out_funcion_w_r    = txn_q.w_r;
    assign out_addr_ram_rtc   = txn_q.addr;
    assign out_dato_inicio    = txn_q.dato;
    assign out_ack            = ack_q;
    assign out_err            = err_q;
    assign out_dato_rd        = dato_rd_q;
    assign out_owner          = owner_q;

    assert property (@(posedge clk) disable iff (!reset) !((|out_ack) && (|out_err)));
    assert property (@(posedge clk) disable iff (!reset) $onehot0(out_ack));
    assert property (@(posedge clk) disable iff (!reset) $onehot0(out_err));

endmodule

// File: tb/tb_rtc_access_arbiter.sv
// Directed bench for rtc_access_arbiter with a hand-driven engine model.
`timescale 1ns/1ps
module tb_rtc_access_arbiter;
    import rtc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  in_req;
    logic [2:0]  in_w_r;
    logic [2:0]  in_last;
    logic [23:0] in_addr;
    logic [23:0] in_dato;
    logic        in_flag_done;
    logic [7:0]  in_dato_leido;
    logic        out_en_funcion_rtc;
    logic        out_funcion_w_r;
    logic [7:0]  out_addr_ram_rtc;
    logic [7:0]  out_dato_inicio;
    logic [2:0]  out_ack;
    logic [2:0]  out_err;
    logic [7:0]  out_dato_rd;
    logic [1:0]  out_owner;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;
    int bad;

    always #5 clk = ~clk;

    rtc_access_arbiter #(
        .TIMEOUT_CYCLES (16'd16),
        .TW             (16)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .in_req             (in_req),
        .in_w_r             (in_w_r),
        .in_last            (in_last),
        .in_addr            (in_addr),
        .in_dato            (in_dato),
        .in_flag_done       (in_flag_done),
        .in_dato_leido      (in_dato_leido),
        .out_en_funcion_rtc (out_en_funcion_rtc),
        .out_funcion_w_r    (out_funcion_w_r),
        .out_addr_ram_rtc   (out_addr_ram_rtc),
        .out_dato_inicio    (out_dato_inicio),
        .out_ack            (out_ack),
        .out_err            (out_err),
        .out_dato_rd        (out_dato_rd),
        .out_owner          (out_owner)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_slot(input logic [1:0] idx, input logic req, input logic w_r,
                            input logic last, input logic [7:0] addr, input logic [7:0] dato);
        in_req[idx]          = req;
        in_w_r[idx]          = w_r;
        in_last[idx]         = last;
        in_addr[8*idx +: 8]  = addr;
        in_dato[8*idx +: 8]  = dato;
    endtask

    // Returns on the first falling edge where the engine enable is seen high.
    task automatic wait_grant(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_en_funcion_rtc && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_grant"}, 32'(out_en_funcion_rtc), 1);
    endtask

    // Engine answers after 'delay' further cycles; leaves the bench in the DONE cycle.
    task automatic serve(input int delay, input logic [7:0] rdata, output int en_cycles);
        en_cycles = 1;
        repeat (delay) begin
            @(negedge clk);
            if (out_en_funcion_rtc) en_cycles++;
        end
        in_flag_done  = 1'b1;
        in_dato_leido = rdata;
        @(negedge clk);
        in_flag_done  = 1'b0;
        in_dato_leido = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset         = 1'b0;
        in_req        = '0;
        in_w_r        = '0;
        in_last       = '0;
        in_addr       = '0;
        in_dato       = '0;
        in_flag_done  = 1'b0;
        in_dato_leido = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_en",    32'(out_en_funcion_rtc), 0);
        check_eq("rst_owner", 32'(out_owner), 3);
        check_eq("rst_ack",   32'(out_ack), 0);
        check_eq("rst_err",   32'(out_err), 0);
        check_eq("rst_rd",    32'(out_dato_rd), 0);
        check_eq("rst_addr",  32'(out_addr_ram_rtc), 0);
        reset = 1'b1;
        @(negedge clk);

        // Single read
        set_slot(REQ_READ, 1'b1, 1'b0, 1'b1, ADDR_SEG, 8'h00);
        wait_grant("rd");
        check_eq("rd_owner", 32'(out_owner), 2);
        check_eq("rd_addr",  32'(out_addr_ram_rtc), 'h21);
        check_eq("rd_wr",    32'(out_funcion_w_r), 0);
        serve(10, 8'h45, cyc);
        check_eq("rd_en_len", cyc, 11);
        check_eq("rd_ack",    32'(out_ack), 4);
        check_eq("rd_en_off", 32'(out_en_funcion_rtc), 0);
        check_eq("rd_data",   32'(out_dato_rd), 'h45);
        in_req[2] = 1'b0;
        @(negedge clk);
        check_eq("rd_ack_1cyc", 32'(out_ack), 0);
        check_eq("rd_owner_rel", 32'(out_owner), 3);

        // Priority: init beats periodic read
        set_slot(REQ_INIT, 1'b1, 1'b1, 1'b1, CTRL_STATUS, 8'hA5);
        set_slot(REQ_READ, 1'b1, 1'b0, 1'b1, ADDR_MIN, 8'h00);
        wait_grant("prio");
        check_eq("prio_owner", 32'(out_owner), 0);
        check_eq("prio_addr",  32'(out_addr_ram_rtc), 'h02);
        check_eq("prio_dato",  32'(out_dato_inicio), 'hA5);
        check_eq("prio_wr",    32'(out_funcion_w_r), 1);
        serve(3, 8'hEE, cyc);
        check_eq("prio_ack",   32'(out_ack), 1);
        check_eq("wr_keeps_rd", 32'(out_dato_rd), 'h45);
        in_req[0] = 1'b0;
        @(negedge clk);
        check_eq("prio_idle_en", 32'(out_en_funcion_rtc), 0);
        check_eq("prio_idle_owner", 32'(out_owner), 3);
        @(negedge clk);
        check_eq("prio2_en",    32'(out_en_funcion_rtc), 1);
        check_eq("prio2_owner", 32'(out_owner), 2);
        check_eq("prio2_addr",  32'(out_addr_ram_rtc), 'h22);
        serve(2, 8'h3C, cyc);
        check_eq("prio2_ack",  32'(out_ack), 4);
        check_eq("prio2_data", 32'(out_dato_rd), 'h3C);
        in_req[2] = 1'b0;
        @(negedge clk);

        // Burst lock: config holds the engine over three writes while init waits
        set_slot(REQ_CONF, 1'b1, 1'b1, 1'b0, ADDR_T_SEG, 8'h11);
        wait_grant("b1");
        check_eq("b1_owner", 32'(out_owner), 1);
        check_eq("b1_addr",  32'(out_addr_ram_rtc), 'h41);
        set_slot(REQ_INIT, 1'b1, 1'b1, 1'b1, CTRL_INIT, 8'h77);
        serve(2, 8'h00, cyc);
        check_eq("b1_ack", 32'(out_ack), 2);
        set_slot(REQ_CONF, 1'b1, 1'b1, 1'b0, ADDR_T_MIN, 8'h22);
        @(negedge clk);
        check_eq("b1_gap_en",  32'(out_en_funcion_rtc), 0);
        check_eq("b1_locked",  32'(out_owner), 1);
        @(negedge clk);
        check_eq("b2_owner", 32'(out_owner), 1);
        check_eq("b2_addr",  32'(out_addr_ram_rtc), 'h42);
        check_eq("b2_dato",  32'(out_dato_inicio), 'h22);
        serve(2, 8'h00, cyc);
        check_eq("b2_ack", 32'(out_ack), 2);
        set_slot(REQ_CONF, 1'b1, 1'b1, 1'b1, ADDR_T_HORA, 8'h33);
        @(negedge clk);
        check_eq("b2_gap_en", 32'(out_en_funcion_rtc), 0);
        @(negedge clk);
        check_eq("b3_owner", 32'(out_owner), 1);
        check_eq("b3_addr",  32'(out_addr_ram_rtc), 'h43);
        serve(1, 8'h00, cyc);
        check_eq("b3_ack", 32'(out_ack), 2);
        in_req[1] = 1'b0;
        @(negedge clk);
        check_eq("b3_unlock", 32'(out_owner), 3);
        @(negedge clk);
        check_eq("b_init_owner", 32'(out_owner), 0);
        check_eq("b_init_addr",  32'(out_addr_ram_rtc), 'h10);
        check_eq("b_init_dato",  32'(out_dato_inicio), 'h77);
        serve(1, 8'h00, cyc);
        check_eq("b_init_ack", 32'(out_ack), 1);
        in_req[0] = 1'b0;
        @(negedge clk);

        // Timeout on a locked burst: err clears the lock and init takes over
        set_slot(REQ_CONF, 1'b1, 1'b1, 1'b0, CMD_XFER_TIME, 8'h5A);
        wait_grant("to");
        set_slot(REQ_INIT, 1'b1, 1'b0, 1'b1, ADDR_DIA, 8'h00);
        bad = 0;
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            if (out_err != 3'b000 || out_ack != 3'b000 || !out_en_funcion_rtc) bad++;
        end
        check_eq("to_early", bad, 0);
        @(negedge clk);
        check_eq("to_err", 32'(out_err), 2);
        check_eq("to_no_ack", 32'(out_ack), 0);
        check_eq("to_en_off", 32'(out_en_funcion_rtc), 0);
        @(negedge clk);
        check_eq("to_unlock", 32'(out_owner), 3);
        @(negedge clk);
        check_eq("to_next_owner", 32'(out_owner), 0);
        check_eq("to_next_addr",  32'(out_addr_ram_rtc), 'h24);
        serve(4, 8'h99, cyc);
        check_eq("to_next_ack",  32'(out_ack), 1);
        check_eq("to_next_data", 32'(out_dato_rd), 'h99);
        in_req[0] = 1'b0;
        in_req[1] = 1'b0;
        @(negedge clk);

        // Done on the expiring cycle: done wins
        set_slot(REQ_READ, 1'b1, 1'b0, 1'b1, ADDR_MES, 8'h00);
        wait_grant("col");
        serve(15, 8'h5E, cyc);
        check_eq("col_en_len", cyc, 16);
        check_eq("col_ack",  32'(out_ack), 4);
        check_eq("col_err",  32'(out_err), 0);
        check_eq("col_data", 32'(out_dato_rd), 'h5E);
        in_req[2] = 1'b0;
        @(negedge clk);

        // Reset in the middle of a transaction
        set_slot(REQ_READ, 1'b1, 1'b0, 1'b1, ADDR_ANIO, 8'h00);
        wait_grant("mid");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("mid_en",    32'(out_en_funcion_rtc), 0);
        check_eq("mid_owner", 32'(out_owner), 3);
        check_eq("mid_ack",   32'(out_ack), 0);
        check_eq("mid_err",   32'(out_err), 0);
        in_req[2] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (out_ack != 3'b000 || out_err != 3'b000 || out_en_funcion_rtc) bad++;
        end
        check_eq("mid_dropped", bad, 0);
        set_slot(REQ_INIT, 1'b1, 1'b1, 1'b1, CMD_XFER_ALL, 8'hC3);
        wait_grant("post");
        check_eq("post_owner", 32'(out_owner), 0);
        check_eq("post_addr",  32'(out_addr_ram_rtc), 'hF2);
        check_eq("post_dato",  32'(out_dato_inicio), 'hC3);
        serve(2, 8'h00, cyc);
        check_eq("post_ack", 32'(out_ack), 1);
        check_eq("post_rd",  32'(out_dato_rd), 0);
        in_req[0] = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
